// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank engine.
// Holds the FSM state enum, unit/initial rank helpers and width helpers.
package pagerank_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ACCUM,
      S_WRITE,
      S_CHECK,
      S_DONE
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // ONE = 2^width, the Q0.width value of 1.0
   function automatic longint one(input int width);
      return longint'(1) << width;
   endfunction

   function automatic longint init_rank(input int width, input int n);
      return one(width) / n;
   endfunction

   // N terms below ONE plus the teleport term fit with one spare bit
   function automatic int acc_w(input int width, input int n);
      return width + clog2(n) + 1;
   endfunction

endpackage

// File: rtl/pagerank_if.sv
// Control/config/read-port bundle of the PageRank engine.
// master drives start, config and rd_addr; slave returns status and rd_data.
interface pagerank_if
   import pagerank_pkg::*;
#(
   parameter int N      = 16,
   parameter int WIDTH  = 16,
   parameter int ITER_W = 8
) ();
   localparam int AW = clog2(N);

   logic                 start;
   logic [N*N-1:0]       adjacency;
   logic [N*WIDTH-1:0]   weights;
   logic [WIDTH-1:0]     damping;
   logic [WIDTH-1:0]     tol;
   logic [ITER_W-1:0]    max_iter;
   logic                 busy;
   logic                 done;
   logic                 converged;
   logic [ITER_W-1:0]    iter_count;
   logic [AW-1:0]        rd_addr;
   logic [WIDTH-1:0]     rd_data;

   modport master (
      output start, adjacency, weights, damping, tol, max_iter, rd_addr,
      input  busy, done, converged, iter_count, rd_data
   );

   modport slave (
      input  start, adjacency, weights, damping, tol, max_iter, rd_addr,
      output busy, done, converged, iter_count, rd_data
   );
endinterface

// File: rtl/pagerank_mac.sv
// Registered multiply-accumulate with saturating read-out.
// clr loads init, en adds (gain*w*r)>>2W; sat is acc clamped to 2^W-1.
module pagerank_mac
   import pagerank_pkg::*;
#(
   parameter int N     = 16,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] init,
   input  logic [WIDTH:0]   gain,
   input  logic [WIDTH-1:0] w,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] sat
);
   localparam int AW = acc_w(WIDTH, N);
   localparam int PW = 3 * WIDTH + 1;

   logic [PW-1:0]  prod;
   logic [WIDTH:0] term;
   logic [AW-1:0]  acc_q, acc_d;

   assign prod = PW'(gain) * PW'(w) * PW'(r);
   assign term = (WIDTH + 1)'(prod >> (2 * WIDTH));

   always_comb begin
      acc_d = acc_q;
      if (clr)
         acc_d = AW'(init);
      else if (en)
         acc_d = acc_q + AW'(term);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign sat = (|acc_q[AW-1:WIDTH]) ? '1 : acc_q[WIDTH-1:0];

endmodule

// File: rtl/pagerank_engine.sv
// Jacobi PageRank iteration engine, one MAC per cycle, double-buffered ranks.
// Ports: clk, reset (async, high), bus (pagerank_if slave: start/config in, status and rank read out).
module pagerank_engine
   import pagerank_pkg::*;
#(
   parameter int N      = 16,
   parameter int WIDTH  = 16,
   parameter int ITER_W = 8
) (
   input logic       clk,
   input logic       reset,
   pagerank_if.slave bus
);
   localparam int LG = clog2(N);
   localparam logic [WIDTH-1:0] INIT_R = WIDTH'(init_rank(WIDTH, N));
   localparam logic [WIDTH:0]   ONE_V  = (WIDTH + 1)'(one(WIDTH));

   state_e state_q, state_d;

   logic [N*N-1:0]     adj_q, adj_d;
   logic [N*WIDTH-1:0] w_q, w_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [WIDTH-1:0]   tol_q, tol_d;
   logic [WIDTH-1:0]   maxd_q, maxd_d;
   logic [ITER_W-1:0]  maxit_q, maxit_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic               conv_q, conv_d;
   logic               sel_q, sel_d;
   logic [LG-1:0]      p_q, p_d;
   logic [LG-1:0]      k_q, k_d;
   logic [WIDTH-1:0]   bank_q [2][N];
   logic [WIDTH-1:0]   bank_d [2][N];

   logic               busy, done, accept, mac_clr, mac_en;
   logic               last_k, last_p, conv_now, finish;
   logic [ITER_W-1:0]  iter_inc;
   logic [WIDTH-1:0]   mac_sat, old_p, delta;

   assign last_k   = (k_q == LG'(N - 1));
   assign last_p   = (p_q == LG'(N - 1));
   assign iter_inc = iter_q + ITER_W'(1);
   assign conv_now = (maxd_q <= tol_q);
   assign finish   = conv_now || (iter_inc == maxit_q);
   assign old_p    = bank_q[sel_q][p_q];
   assign delta    = (mac_sat >= old_p) ? mac_sat - old_p
                                        : old_p - mac_sat;

   pagerank_mac #(.N(N), .WIDTH(WIDTH)) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .init  (d_q >> LG),
      .gain  (ONE_V - {1'b0, d_q}),
      .w     (w_q[k_q*WIDTH +: WIDTH]),
      .r     (bank_q[sel_q][k_q]),
      .sat   (mac_sat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start) state_d = S_INIT;
         S_INIT:  state_d = S_ACCUM;
         S_ACCUM: if (last_k) state_d = S_WRITE;
         S_WRITE: state_d = last_p ? S_CHECK : S_ACCUM;
         S_CHECK: state_d = finish ? S_DONE : S_ACCUM;
         S_DONE:  state_d = bus.start ? S_INIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The accumulator is preloaded in every cycle that precedes k = 0
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      unique case (state_q)
         S_IDLE:  accept = bus.start;
         S_INIT:  begin busy = 1'b1; mac_clr = 1'b1; end
         S_ACCUM: begin
            busy   = 1'b1;
            mac_en = adj_q[{p_q, k_q}] && (k_q != p_q);
         end
         S_WRITE: begin busy = 1'b1; mac_clr = 1'b1; end
         S_CHECK: begin busy = 1'b1; mac_clr = 1'b1; end
         S_DONE:  begin done = 1'b1; accept = bus.start; end
         default: ;
      endcase
   end

   always_comb begin
      adj_d   = adj_q;
      w_d     = w_q;
      d_d     = d_q;
      tol_d   = tol_q;
      maxit_d = maxit_q;
      maxd_d  = maxd_q;
      iter_d  = iter_q;
      conv_d  = conv_q;
      sel_d   = sel_q;
      p_d     = p_q;
      k_d     = k_q;
      bank_d  = bank_q;
      if (accept) begin
         adj_d   = bus.adjacency;
         w_d     = bus.weights;
         d_d     = bus.damping;
         tol_d   = bus.tol;
         maxit_d = (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
      end
      unique case (state_q)
         S_INIT: begin
            for (int i = 0; i < N; i++)
               bank_d[sel_q][i] = INIT_R;
            iter_d = '0;
            conv_d = 1'b0;
            maxd_d = '0;
            p_d    = '0;
            k_d    = '0;
         end
         S_ACCUM: k_d = k_q + LG'(1);
         S_WRITE: begin
            bank_d[~sel_q][p_q] = mac_sat;
            if (delta > maxd_q) maxd_d = delta;
            p_d = p_q + LG'(1);
            k_d = '0;
         end
         S_CHECK: begin
            sel_d  = ~sel_q;
            iter_d = iter_inc;
            conv_d = conv_now;
            p_d    = '0;
            if (!finish) maxd_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adj_q   <= '0;
         w_q     <= '0;
         d_q     <= '0;
         tol_q   <= '0;
         maxit_q <= '0;
         maxd_q  <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
         sel_q   <= 1'b0;
         p_q     <= '0;
         k_q     <= '0;
         for (int i = 0; i < N; i++) begin
            bank_q[0][i] <= INIT_R;
            bank_q[1][i] <= INIT_R;
         end
      end else begin
         adj_q   <= adj_d;
         w_q     <= w_d;
         d_q     <= d_d;
         tol_q   <= tol_d;
         maxit_q <= maxit_d;
         maxd_q  <= maxd_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
         sel_q   <= sel_d;
         p_q     <= p_d;
         k_q     <= k_d;
         bank_q  <= bank_d;
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.converged  = conv_q;
   assign bus.iter_count = iter_q;
   assign bus.rd_data    = bank_q[sel_q][bus.rd_addr];

endmodule

// File: tb/tb_pagerank_engine.sv
// Bench for pagerank_engine: N=16 and N=4 instances against a PageRank model.
// Directed cases from the feature list plus randomized graphs.
module tb_pagerank_engine;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pagerank_if #(.N(16), .WIDTH(16), .ITER_W(8)) if16 ();
   pagerank_if #(.N(4),  .WIDTH(16), .ITER_W(8)) if4 ();

   pagerank_engine #(.N(16), .WIDTH(16), .ITER_W(8)) u16 (
      .clk(clk), .reset(reset), .bus(if16)
   );
   pagerank_engine #(.N(4), .WIDTH(16), .ITER_W(8)) u4 (
      .clk(clk), .reset(reset), .bus(if4)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit use16   = 1'b1;

   logic [255:0] m_adj;
   longint m_w [16];
   longint m_d, m_tol, m_maxit;
   longint exp_rank [16];
   longint exp1 [16];
   int exp_iter;
   bit exp_conv;

   wire        o_busy = use16 ? if16.busy : if4.busy;
   wire        o_done = use16 ? if16.done : if4.done;
   wire        o_conv = use16 ? if16.converged : if4.converged;
   wire [7:0]  o_iter = use16 ? if16.iter_count : if4.iter_count;
   wire [15:0] o_rd   = use16 ? if16.rd_data : if4.rd_data;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // PageRank power iteration straight from the update rule
   task automatic model(input int n);
      longint one_v, s, dl, md;
      longint old [16];
      longint nw [16];
      int lg, lim;
      one_v = longint'(1) << 16;
      lg = $clog2(n);
      lim = (m_maxit == 0) ? 1 : int'(m_maxit);
      for (int i = 0; i < n; i++) old[i] = one_v / n;
      exp_iter = 0;
      exp_conv = 1'b0;
      for (int it = 1; it <= lim; it++) begin
         md = 0;
         for (int p = 0; p < n; p++) begin
            s = m_d >> lg;
            for (int k = 0; k < n; k++)
               if (m_adj[p*n+k] && k != p)
                  s += ((one_v - m_d) * m_w[k] * old[k]) >> 32;
            nw[p] = (s > one_v - 1) ? one_v - 1 : s;
            dl = nw[p] - old[p];
            if (dl < 0) dl = -dl;
            if (dl > md) md = dl;
         end
         for (int p = 0; p < n; p++) begin
            old[p] = nw[p];
            if (it == 1) exp1[p] = nw[p];
         end
         exp_iter = it;
         if (md <= m_tol) begin
            exp_conv = 1'b1;
            break;
         end
      end
      for (int i = 0; i < n; i++) exp_rank[i] = old[i];
   endtask

   task automatic drive_cfg();
      if16.adjacency = m_adj;
      if4.adjacency  = m_adj[15:0];
      for (int k = 0; k < 16; k++) if16.weights[k*16 +: 16] = 16'(m_w[k]);
      for (int k = 0; k < 4; k++)  if4.weights[k*16 +: 16]  = 16'(m_w[k]);
      if16.damping  = 16'(m_d);
      if4.damping   = 16'(m_d);
      if16.tol      = 16'(m_tol);
      if4.tol       = 16'(m_tol);
      if16.max_iter = 8'(m_maxit);
      if4.max_iter  = 8'(m_maxit);
   endtask

   task automatic set_start(input bit v);
      if16.start = use16 & v;
      if4.start  = ~use16 & v;
   endtask

   task automatic set_addr(input int a);
      if16.rd_addr = 4'(a);
      if4.rd_addr  = 2'(a);
   endtask

   task automatic read_ranks(input int n, input string tag);
      for (int a = 0; a < n; a++) begin
         set_addr(a);
         #1;
         check($sformatf("%s_r%0d", tag, a), o_rd, exp_rank[a]);
         @(negedge clk);
      end
   endtask

   task automatic start_run(input int n);
      use16 = (n == 16);
      model(n);
      drive_cfg();
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
   endtask

   // Returns at the negedge where done is high (or when the budget expires)
   task automatic wait_done(input int n, input bit poke, input string tag);
      int per, cyc;
      per = n * (n + 1) + 1;
      cyc = 0;
      while (o_done !== 1'b1 && cyc < 5000) begin
         if (cyc == 3) check({tag, "_busy"}, o_busy, 1);
         set_start(poke && cyc == 8);
         if (exp_iter >= 2 && cyc == 1 + per + 4) begin
            set_addr(1);
            #1;
            check({tag, "_rd_mid"}, o_rd, exp1[1]);
         end
         cyc++;
         @(negedge clk);
      end
      set_start(1'b0);
      check({tag, "_cycles"}, cyc, 1 + exp_iter * per);
      check({tag, "_done"}, o_done, 1);
      check({tag, "_conv"}, o_conv, exp_conv);
      check({tag, "_iter"}, o_iter, exp_iter);
   endtask

   task automatic finish_run(input int n, input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, o_done, 0);
      check({tag, "_idle"}, o_busy, 0);
      check({tag, "_conv_hold"}, o_conv, exp_conv);
      check({tag, "_iter_hold"}, o_iter, exp_iter);
      read_ranks(n, tag);
   endtask

   task automatic ring4();
      m_adj = '0;
      for (int p = 0; p < 4; p++) m_adj[p*4 + ((p + 3) % 4)] = 1'b1;
      for (int k = 0; k < 16; k++) m_w[k] = 16'hFFFF;
      m_d = 16'h2666;
   endtask

   initial begin
      int dn;
      set_start(1'b0);
      set_addr(0);
      m_adj = '0;
      for (int k = 0; k < 16; k++) m_w[k] = 0;
      m_d = 0; m_tol = 0; m_maxit = 0;
      drive_cfg();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      use16 = 1'b1;
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_iter", o_iter, 0);
      check("rst_conv", o_conv, 0);
      for (int i = 0; i < 16; i++) exp_rank[i] = 16'h1000;
      read_ranks(16, "rst16");
      use16 = 1'b0;
      for (int i = 0; i < 4; i++) exp_rank[i] = 16'h4000;
      read_ranks(4, "rst4");

      // degenerate graph, N=16
      m_adj = '0;
      for (int k = 0; k < 16; k++) m_w[k] = $urandom_range(0, 65535);
      m_d = 16'h2666; m_tol = 0; m_maxit = 8;
      start_run(16);
      wait_done(16, 1'b0, "degen");
      set_addr(5);
      #1;
      check("degen_const", o_rd, 16'h0266);
      finish_run(16, "degen");

      // ring, converges after one iteration
      ring4();
      m_tol = 1; m_maxit = 5;
      start_run(4);
      wait_done(4, 1'b0, "ring");
      set_addr(2);
      #1;
      check("ring_const", o_rd, 16'h3FFF);
      finish_run(4, "ring");

      // ring, limit reached, start mid-run ignored
      ring4();
      m_tol = 0; m_maxit = 1;
      start_run(4);
      wait_done(4, 1'b1, "ringlim");
      finish_run(4, "ringlim");

      // fully connected, d=0, one iteration then restart on done cycle
      m_adj = '1;
      for (int k = 0; k < 16; k++) m_w[k] = 16'hFFFF;
      m_d = 0; m_tol = 0; m_maxit = 1;
      start_run(4);
      wait_done(4, 1'b0, "ones1");
      set_addr(0);
      #1;
      check("ones1_const", o_rd, 16'hBFFD);
      m_maxit = 2;
      model(4);
      drive_cfg();
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      check("ones_restart", o_busy, 1);
      wait_done(4, 1'b0, "ones2");
      set_addr(3);
      #1;
      check("ones2_const", o_rd, 16'hFFFF);
      finish_run(4, "ones2");

      // reset during iteration 2
      start_run(4);
      repeat (30) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy", o_busy, 0);
      check("abort_done", o_done, 0);
      check("abort_iter", o_iter, 0);
      for (int i = 0; i < 4; i++) exp_rank[i] = 16'h4000;
      read_ranks(4, "abort");
      reset = 1'b0;
      dn = 0;
      repeat (30) begin
         @(negedge clk);
         if (o_done === 1'b1) dn++;
      end
      check("abort_no_done", dn, 0);
      start_run(4);
      wait_done(4, 1'b0, "after");
      finish_run(4, "after");

      // randomized graphs
      for (int t = 0; t < 8; t++) begin
         int n;
         n = (t < 6) ? 4 : 16;
         for (int i = 0; i < 256; i++)
            m_adj[i] = ($urandom_range(0, 2) != 0);
         for (int k = 0; k < 16; k++) m_w[k] = $urandom_range(0, 65535);
         m_d = $urandom_range(0, 65535);
         m_tol = $urandom_range(0, 64);
         m_maxit = (n == 4) ? $urandom_range(0, 4) : $urandom_range(0, 2);
         start_run(n);
         wait_done(n, 1'b0, $sformatf("rnd%0d", t));
         finish_run(n, $sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
